// File: rtl/addsub_serial_chunk.sv
// Multi-cycle adder/subtractor: WIDTH-bit a+b or a-b, CHUNK bits per clock, start/busy/done handshake.
// Optional saturation on signed overflow is enabled by defining ADDSUB_SAT_EN.
module addsub_serial_chunk #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("addsub_serial_chunk: WIDTH must be >= 2");
        end
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
            $error("addsub_serial_chunk: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             m_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] shadow_q;

    logic             accept;
    logic             last_chunk;
    logic             carry_in;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] full_raw;
    logic [WIDTH-1:0] full_res;
    logic             c_fin;
    logic             c_msb_in;
    logic             ovf_fin;

    assign accept     = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_chunk = (idx_q == LAST_IDX);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = start ? BUSY : IDLE;
            BUSY:    state_d = last_chunk ? DONE : BUSY;
            DONE:    state_d = start ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            BUSY:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Chunk datapath
    // -------------------------------------------------------------------------
    // The first chunk takes its carry-in straight from the captured mode bit,
    // which provides the +1 of the two's complement subtract.
    assign carry_in  = (idx_q == '0) ? m_q : carry_q;
    assign a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    assign b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    assign chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_in};

    always_comb begin
        full_raw = shadow_q;
        full_raw[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Carry into the MSB recovered from the MSB sum bit; works for any CHUNK, including 1.
    assign c_fin    = chunk_sum[CHUNK];
    assign c_msb_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ full_raw[WIDTH-1];
    assign ovf_fin  = c_msb_in ^ c_fin;

`ifdef ADDSUB_SAT_EN
    always_comb begin
        full_res = full_raw;
        if (ovf_fin) begin
            full_res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign full_res = full_raw;
`endif

    // -------------------------------------------------------------------------
    // Operand capture, chunk accumulation and result/flag update
    // -------------------------------------------------------------------------
    // Partial sums go to shadow_q so the visible result stays stable until the
    // last chunk commits the whole word at DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b ^ {WIDTH{m}};
            m_q     <= m;
            carry_q <= m;
            idx_q   <= '0;
        end else if (state_q == BUSY) begin
            shadow_q <= full_raw;
            carry_q  <= chunk_sum[CHUNK];
            if (last_chunk) begin
                result <= full_res;
                c_out  <= c_fin;
                ovf    <= ovf_fin;
                zero   <= (full_res == '0);
                neg    <= full_res[WIDTH-1];
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_addsub_serial_chunk.sv
// Directed, table-driven bench for addsub_serial_chunk (WIDTH=16 with CHUNK=4 and CHUNK=16).
// Expected results adjust for saturation when ADDSUB_SAT_EN is defined.
module tb_addsub_serial_chunk;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, m;
    logic [W-1:0]  a, b;
    logic          busy, done, c_out, ovf, zero, neg;
    logic [W-1:0]  result;

    logic          start2, m2;
    logic [W-1:0]  a2, b2;
    logic          busy2, done2, c_out2, ovf2, zero2, neg2;
    logic [W-1:0]  result2;

    always #5 clk = ~clk;

    addsub_serial_chunk #(.WIDTH(W), .CHUNK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .m(m),
        .busy(busy), .done(done), .result(result), .c_out(c_out),
        .ovf(ovf), .zero(zero), .neg(neg)
    );

    addsub_serial_chunk #(.WIDTH(W), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .m(m2),
        .busy(busy2), .done(done2), .result(result2), .c_out(c_out2),
        .ovf(ovf2), .zero(zero2), .neg(neg2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
    } vec_t;

    function automatic vec_t expect_of(input vec_t v);
        vec_t e = v;
`ifdef ADDSUB_SAT_EN
        if (e.o) begin
            e.r = e.a[W-1] ? 16'h8000 : 16'h7FFF;
            e.z = 1'b0;
            e.n = e.r[W-1];
        end
`endif
        return e;
    endfunction

    // Called #1 after an edge; the next edge accepts the operation.
    task automatic run_op(input vec_t v, input logic [W-1:0] prev_r, input string tag);
        vec_t e;
        int   n;
        e = expect_of(v);
        a = v.a; b = v.b; m = v.m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~v.a; b = ~v.b; m = ~v.m;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_nodone"}, 32'(done), 32'd0);
        n = 0;
        while (!done && n < 8) begin
            chk({tag, "_hold"}, 32'(result), 32'(prev_r));
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(e.r));
        chk({tag, "_c_out"}, 32'(c_out), 32'(e.c));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.o));
        chk({tag, "_zero"}, 32'(zero), 32'(e.z));
        chk({tag, "_neg"}, 32'(neg), 32'(e.n));
    endtask

    vec_t        vecs[10];
    vec_t        tmp;
    logic [W-1:0] prev;
    int          n;
    int          done_seen;

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0003, 16'h0004, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'hA5A5, 16'h5A5A, 1'b1, 16'h4B4B, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; m = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; m2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {25'd0, busy, done, c_out, ovf, zero, neg, 1'b0}, 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_state16", {25'd0, busy2, done2, c_out2, ovf2, zero2, neg2, 1'b0}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vectors 3 and 4 run back-to-back: start is raised in the DONE cycle.
        prev = '0;
        for (int i = 0; i < 10; i++) begin
            if (i % 3 == 0) begin
                @(posedge clk); #1;
                chk($sformatf("gap%0d_done", i), 32'(done), 32'd0);
                chk($sformatf("gap%0d_busy", i), 32'(busy), 32'd0);
            end
            run_op(vecs[i], prev, $sformatf("vec%0d", i));
            tmp  = expect_of(vecs[i]);
            prev = tmp.r;
        end

        // start re-pulsed mid-BUSY must be ignored
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h0FFF; m = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0001; m = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        while (!done && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("restart_latency", 32'(n), 32'd4);
        chk("restart_result", 32'(result), 32'h2233);
        chk("restart_c_out", 32'(c_out), 32'd0);
        @(posedge clk); #1;
        chk("restart_idle", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset mid-BUSY aborts with no done pulse
        a = 16'h1111; b = 16'h2222; m = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {25'd0, busy, done, c_out, ovf, zero, neg, 1'b0}, 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        tmp = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0};
        run_op(tmp, 16'h0000, "post_abort");

        // CHUNK == WIDTH: single BUSY cycle
        a2 = 16'hFFFF; b2 = 16'h0001; m2 = 1'b0; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("c16_busy", 32'(busy2), 32'd1);
        chk("c16_nodone", 32'(done2), 32'd0);
        @(posedge clk); #1;
        chk("c16_done", 32'(done2), 32'd1);
        chk("c16_result", 32'(result2), 32'h0000);
        chk("c16_c_out", 32'(c_out2), 32'd1);
        chk("c16_zero", 32'(zero2), 32'd1);
        chk("c16_ovf", 32'(ovf2), 32'd0);
        chk("c16_neg", 32'(neg2), 32'd0);
        @(posedge clk); #1;
        chk("c16_pulse", 32'(done2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
